// File: rtl/ctrl_seq_pkg.sv
// Shared encodings and entry layouts for the ALPIDE slow-control command sequencer.
package ctrl_seq_pkg;

  localparam logic [1:0] TYPE_CMD   = 2'd0;
  localparam logic [1:0] TYPE_WR    = 2'd1;
  localparam logic [1:0] TYPE_RD    = 2'd2;
  localparam logic [1:0] TYPE_DELAY = 2'd3;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_REL  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;

  localparam int unsigned CMD_W = 50;
  localparam int unsigned RES_W = 18;

  typedef struct packed {
    logic [1:0]  typ;
    logic [7:0]  opcode;
    logic [7:0]  chipid;
    logic [15:0] addr;
    logic [15:0] data;
  } cmd_t;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
    logic        timeout;
  } res_t;

endpackage

// File: rtl/ctrl_seq_if.sv
// Level request / ack handshake between the sequencer (master) and the ctrl serialiser (slave).
interface ctrl_seq_if;
  logic [7:0]  opcode;
  logic [7:0]  chipid;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        cmd;
  logic        wr;
  logic        rd;
  logic [15:0] rdata;
  logic        err;
  logic        ack;

  modport master (output opcode, chipid, addr, wdata, cmd, wr, rd,
                  input  rdata, err, ack);
  modport slave  (input  opcode, chipid, addr, wdata, cmd, wr, rd,
                  output rdata, err, ack);
endinterface

// File: rtl/ctrl_seq_sc_fifo.sv
// sc_fifo: single-clock FIFO with flush; pushes while full or flushing are dropped.
module sc_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: issues queued CMD/WR/RD/DELAY entries to the ctrl serialiser one at a time.
// Optional REQ watchdog enabled by defining CTRL_SEQ_TIMEOUT_EN.
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned CMD_DEPTH   = 16,
  parameter int unsigned RES_DEPTH   = 16,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        push_i,
  input  logic [1:0]  push_type_i,
  input  logic [7:0]  push_opcode_i,
  input  logic [7:0]  push_chipid_i,
  input  logic [15:0] push_addr_i,
  input  logic [15:0] push_data_i,
  output logic        push_ready_o,
  input  logic        flush_i,
  input  logic        res_pop_i,
  output logic        res_valid_o,
  output logic [15:0] res_data_o,
  output logic        res_err_o,
  output logic        res_timeout_o,
  output logic        busy_o,
  output logic [15:0] n_done_o,
  ctrl_seq_if.master  ctrl
);

  if (CMD_DEPTH < 2 || RES_DEPTH < 2 || TIMEOUT_CYC == 0) begin : g_bad_param
    $error("ctrl_seq: invalid parameter set");
  end

  cmd_t        cmd_wdata, cmd_head, fld_q, fld_d;
  res_t        res_wdata, res_head;
  logic        cmd_full, cmd_empty, cmd_pop;
  logic        res_full, res_empty, res_push;
  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] n_done_q, n_done_d;
  logic        cmd_q, cmd_d, wr_q, wr_d, rd_q, rd_d;
  logic        rdy_q;
  logic        wd_expire;

  assign cmd_wdata = '{push_type_i, push_opcode_i, push_chipid_i, push_addr_i, push_data_i};

  sc_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (flush_i),
    .push_i  (push_i && rdy_q),
    .wdata_i (cmd_wdata),
    .pop_i   (cmd_pop),
    .rdata_o (cmd_head),
    .full_o  (cmd_full),
    .empty_o (cmd_empty)
  );

  sc_fifo #(.WIDTH(RES_W), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (1'b0),
    .push_i  (res_push),
    .wdata_i (res_wdata),
    .pop_i   (res_pop_i),
    .rdata_o (res_head),
    .full_o  (res_full),
    .empty_o (res_empty)
  );

`ifdef CTRL_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;

  // Counts REQ cycles; cleared whenever the FSM is elsewhere.
  always_comb begin
    wd_d = '0;
    if (state_q == S_REQ) wd_d = wd_q + WD_W'(1);
  end
  assign wd_expire = (state_q == S_REQ) && (wd_q == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) wd_q <= '0;
    else          wd_q <= wd_d;
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    fld_d     = fld_q;
    cnt_d     = cnt_q;
    n_done_d  = n_done_q;
    cmd_pop   = 1'b0;
    res_push  = 1'b0;
    res_wdata = '0;
    case (state_q)
      // An RD head waits for result space; nothing behind it may overtake.
      S_IDLE: begin
        if (!cmd_empty && (cmd_head.typ != TYPE_RD || !res_full)) begin
          cmd_pop = 1'b1;
          fld_d   = cmd_head;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (fld_q.typ != TYPE_DELAY) begin
          state_d = S_REQ;
        end else if (fld_q.data == '0) begin
          n_done_d = n_done_q + 16'd1;
          state_d  = S_IDLE;
        end else begin
          cnt_d   = fld_q.data - 16'd1;
          state_d = S_WAIT;
        end
      end
      S_REQ: begin
        if (ctrl.ack) begin
          res_wdata.data = ctrl.rdata;
          res_wdata.err  = ctrl.err;
          res_push       = (fld_q.typ == TYPE_RD);
          n_done_d       = n_done_q + 16'd1;
          state_d        = S_REL;
        end else if (wd_expire) begin
          res_wdata.timeout = 1'b1;
          res_push          = (fld_q.typ == TYPE_RD);
          n_done_d          = n_done_q + 16'd1;
          state_d           = S_REL;
        end
      end
      S_REL: begin
        if (!ctrl.ack) state_d = S_IDLE;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          n_done_d = n_done_q + 16'd1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    cmd_d = (state_d == S_REQ) && (fld_d.typ == TYPE_CMD);
    wr_d  = (state_d == S_REQ) && (fld_d.typ == TYPE_WR);
    rd_d  = (state_d == S_REQ) && (fld_d.typ == TYPE_RD);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      fld_q    <= '0;
      cnt_q    <= '0;
      n_done_q <= '0;
      cmd_q    <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      fld_q    <= fld_d;
      cnt_q    <= cnt_d;
      n_done_q <= n_done_d;
      cmd_q    <= cmd_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      rdy_q    <= 1'b1;
    end
  end

  assign ctrl.opcode = fld_q.opcode;
  assign ctrl.chipid = fld_q.chipid;
  assign ctrl.addr   = fld_q.addr;
  assign ctrl.wdata  = fld_q.data;
  assign ctrl.cmd    = cmd_q;
  assign ctrl.wr     = wr_q;
  assign ctrl.rd     = rd_q;

  // Head fields are masked so an empty FIFO presents zeros, not stale storage.
  assign push_ready_o  = rdy_q && !cmd_full && !flush_i;
  assign busy_o        = (state_q != S_IDLE) || !cmd_empty;
  assign n_done_o      = n_done_q;
  assign res_valid_o   = !res_empty;
  assign res_data_o    = res_empty ? 16'd0 : res_head.data;
  assign res_err_o     = !res_empty && res_head.err;
  assign res_timeout_o = !res_empty && res_head.timeout;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed self-checking bench for ctrl_seq; the ctrl side is played by hand-timed acks.
module tb_ctrl_seq;
  import ctrl_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push = 1'b0, flush = 1'b0, res_pop = 1'b0;
  logic [1:0]  push_type = '0;
  logic [7:0]  push_opcode = '0, push_chipid = '0;
  logic [15:0] push_addr = '0, push_data = '0;
  logic        push_ready, res_valid, res_err, res_timeout, busy;
  logic [15:0] res_data, n_done;
  int          errors = 0;
  int          checks = 0;
  int          n;

  ctrl_seq_if cif ();

  always #5 clk = ~clk;

  ctrl_seq #(.CMD_DEPTH(16), .RES_DEPTH(16), .TIMEOUT_CYC(16)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .push_i        (push),
    .push_type_i   (push_type),
    .push_opcode_i (push_opcode),
    .push_chipid_i (push_chipid),
    .push_addr_i   (push_addr),
    .push_data_i   (push_data),
    .push_ready_o  (push_ready),
    .flush_i       (flush),
    .res_pop_i     (res_pop),
    .res_valid_o   (res_valid),
    .res_data_o    (res_data),
    .res_err_o     (res_err),
    .res_timeout_o (res_timeout),
    .busy_o        (busy),
    .n_done_o      (n_done),
    .ctrl          (cif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_entry(input logic [1:0] t, input logic [7:0] op, input logic [7:0] chip,
                            input logic [15:0] addr, input logic [15:0] data);
    push_type = t; push_opcode = op; push_chipid = chip; push_addr = addr; push_data = data;
    push = 1'b1;
    tick();
    push = 1'b0;
  endtask

  // Ticks until some request level is high; n = edges waited.
  task automatic wait_req(output int cnt);
    cnt = 0;
    while (!(cif.cmd || cif.wr || cif.rd) && cnt < 60) begin
      tick();
      cnt++;
    end
    chk("wait_req_bound", 32'(cnt < 60), 32'd1);
  endtask

  task automatic ack(input logic [15:0] data, input logic err);
    cif.rdata = data; cif.err = err; cif.ack = 1'b1;
    tick();
    cif.ack = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    cif.rdata = '0; cif.err = 1'b0; cif.ack = 1'b0;

    // Reset state
    #12;
    chk("rst_push_ready", push_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_n_done", n_done, 0);
    chk("rst_req", {cif.cmd, cif.wr, cif.rd}, 0);
    chk("rst_res_valid", res_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("post_rst_push_ready", push_ready, 1);

    // 1: WR, request rises on the third cycle, fields held
    push_entry(TYPE_WR, 8'h9C, 8'h10, 16'h0001, 16'hBEEF);
    chk("t1_wr_c1", cif.wr, 0);
    tick();
    chk("t1_wr_load", cif.wr, 0);
    chk("t1_fields", {cif.opcode, cif.chipid, cif.addr, cif.wdata}, {8'h9C, 8'h10, 16'h0001, 16'hBEEF});
    tick();
    chk("t1_wr_req", {cif.cmd, cif.wr, cif.rd}, 3'b010);
    repeat (3) tick();
    chk("t1_wr_held", cif.wr, 1);
    chk("t1_data_held", cif.wdata, 16'hBEEF);
    ack(16'h0000, 1'b0);
    chk("t1_wr_rel", cif.wr, 0);
    chk("t1_n_done", n_done, 1);
    chk("t1_no_res", res_valid, 0);
    chk("t1_busy", busy, 0);
    chk("t1_op_held", cif.opcode, 8'h9C);

    // 2: RD returns data with err set
    push_entry(TYPE_RD, 8'h4E, 8'h10, 16'h0004, 16'h0000);
    wait_req(n);
    chk("t2_rd", {cif.cmd, cif.wr, cif.rd}, 3'b001);
    chk("t2_addr", cif.addr, 16'h0004);
    ack(16'h1234, 1'b1);
    chk("t2_res_valid", res_valid, 1);
    chk("t2_res", {res_data, res_err, res_timeout}, {16'h1234, 1'b1, 1'b0});
    chk("t2_n_done", n_done, 2);
    res_pop = 1'b1; tick(); res_pop = 1'b0;
    chk("t2_popped", res_valid, 0);

    // 3: 17 RDs against a 16-entry result FIFO
    for (int i = 0; i < 17; i++) push_entry(TYPE_RD, 8'h4E, 8'h10, 16'(i), 16'h0000);
    chk("t3_cmd_full", push_ready, 0);
    push_entry(TYPE_RD, 8'h4E, 8'h10, 16'hDEAD, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      wait_req(n);
      chk("t3_addr", cif.addr, 16'(i));
      ack(16'hA000 + 16'(i), 1'b0);
    end
    repeat (8) tick();
    chk("t3_rd_stalled", cif.rd, 0);
    chk("t3_busy_stalled", busy, 1);
    res_pop = 1'b1; tick(); res_pop = 1'b0;
    wait_req(n);
    chk("t3_last_rd", {cif.rd, cif.addr}, {1'b1, 16'h0010});
    ack(16'hA010, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      chk("t3_drain", res_data, 16'hA000 + 16'(i));
      res_pop = 1'b1; tick(); res_pop = 1'b0;
    end
    chk("t3_empty", res_valid, 0);
    chk("t3_dropped_push", busy, 0);
    chk("t3_n_done", n_done, 19);

    // 4: CMD, DELAY 5, CMD spacing; then DELAY 0
    push_entry(TYPE_CMD, 8'h63, 8'h10, 16'h0000, 16'h0000);
    push_entry(TYPE_DELAY, 8'h00, 8'h00, 16'h0000, 16'd5);
    push_entry(TYPE_CMD, 8'h55, 8'h10, 16'h0000, 16'h0000);
    wait_req(n);
    ack(16'h0000, 1'b0);
    wait_req(n);
    chk("t4_gap", n, 9);
    chk("t4_n_done_mid", n_done, 21);
    chk("t4_second_cmd", {cif.cmd, cif.opcode}, {1'b1, 8'h55});
    ack(16'h0000, 1'b0);
    push_entry(TYPE_DELAY, 8'h00, 8'h00, 16'h0000, 16'd0);
    push_entry(TYPE_CMD, 8'h77, 8'h10, 16'h0000, 16'h0000);
    wait_req(n);
    chk("t4_delay0_gap", n, 3);
    ack(16'h0000, 1'b0);
    chk("t4_n_done", n_done, 24);

    // 5: flush during first REQ
    for (int i = 1; i <= 4; i++) push_entry(TYPE_CMD, 8'(i), 8'h10, 16'h0000, 16'h0000);
    flush = 1'b1;
    #1;
    chk("t5_ready_flush", push_ready, 0);
    tick();
    flush = 1'b0;
    chk("t5_inflight", {cif.cmd, cif.opcode, busy}, {1'b1, 8'h01, 1'b1});
    ack(16'h0000, 1'b0);
    chk("t5_n_done", n_done, 25);
    chk("t5_busy", busy, 0);
    repeat (5) tick();
    chk("t5_no_more", {cif.cmd, n_done}, {1'b0, 16'd25});

    // ack outside REQ is ignored
    cif.ack = 1'b1;
    push_entry(TYPE_DELAY, 8'h00, 8'h00, 16'h0000, 16'd2);
    repeat (6) tick();
    cif.ack = 1'b0;
    chk("stray_ack_n_done", n_done, 26);
    chk("stray_ack_idle", {busy, cif.cmd, cif.wr, cif.rd}, 4'b0000);

`ifdef CTRL_SEQ_TIMEOUT_EN
    // 6: RD never acked
    push_entry(TYPE_RD, 8'h4E, 8'h10, 16'h0055, 16'h0000);
    wait_req(n);
    n = 0;
    while (cif.rd && n < 40) begin
      tick();
      n++;
    end
    chk("t6_req_cycles", n, 16);
    tick();
    chk("t6_res", {res_valid, res_data, res_err, res_timeout}, {1'b1, 16'h0000, 1'b0, 1'b1});
    chk("t6_n_done", n_done, 27);
    res_pop = 1'b1; tick(); res_pop = 1'b0;
`endif

    // Asynchronous reset mid-REQ
    push_entry(TYPE_CMD, 8'h3C, 8'h22, 16'h0000, 16'h0000);
    wait_req(n);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {cif.cmd, cif.wr, cif.rd}, 0);
    chk("arst_outs", {push_ready, busy, res_valid, n_done, cif.opcode}, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("arst_ready", push_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
